uart_rx_buf: RTL and testbench
==============================

UART_RX_BUF -- requirements
Module: uart_rx_buf

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, receive buffer depth in bytes (power of two, 2..16).
REQ-004 SHALL have port i_Clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_UART_RX  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 SHALL have port o_data  output  8  byte at FIFO head, valid only while o_valid=1.
REQ-008 SHALL have port o_valid  output  1  FIFO non-empty.
REQ-009 SHALL have port i_ready  input  1  consumer accepts o_data; pop occurs when o_valid & i_ready.
REQ-010 SHALL have port o_count  output  5  bytes currently held in FIFO.
REQ-011 SHALL have port o_frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-012 SHALL have port o_overrun  output  1  one-cycle pulse when a received byte is dropped because the FIFO is full.

Function
REQ-013 SHALL pass i_UART_RX through a 2-flop synchronizer; all receive logic uses the synchronized value.
REQ-014 SHALL use CLKS_PER_BIT = CLK_FREQ/BAUD (integer division; 217 at defaults) and HALF_BIT = CLKS_PER_BIT/2 (108).
REQ-015 SHALL implement receive states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-016 IDLE: on synchronized line = 0, SHALL clear the bit counter and enter START.
REQ-017 START: after HALF_BIT cycles, SHALL resample the line; 0 enters DATA, 1 (glitch) returns to IDLE with no flags raised.
REQ-018 DATA: SHALL sample once every CLKS_PER_BIT cycles and shift each sample into the shift register LSB first; after the 8th sample it SHALL enter STOP.
REQ-019 STOP: after CLKS_PER_BIT cycles, SHALL sample the line; 1 pushes the byte and returns to IDLE.
REQ-020 STOP: a 0 sample SHALL pulse o_frame_err, discard the byte, and enter WAIT_HIGH.
REQ-021 WAIT_HIGH: SHALL stay there until the synchronized line = 1, then enter IDLE; this blocks break conditions from re-triggering reception.
REQ-022 FIFO SHALL be first-word-fall-through: o_data is the head entry and o_valid = (o_count != 0).
REQ-023 A pushed byte SHALL appear on o_data with o_valid=1 on the cycle after the stop-bit sample cycle, provided the FIFO was empty.
REQ-024 A push SHALL be accepted if o_count < FIFO_DEPTH or a pop occurs in the same cycle; otherwise the byte is dropped and o_overrun pulses for one cycle.
REQ-025 Simultaneous push and pop SHALL leave o_count unchanged and preserve byte order.
REQ-026 Pop while empty SHALL have no effect; i_ready is ignored while o_valid=0.
REQ-027 Read/write pointers SHALL wrap modulo FIFO_DEPTH; o_count SHALL range 0..FIFO_DEPTH.

Reset
REQ-028 During rst=1: state=IDLE, synchronizer flops=1, counters=0, pointers=0, o_count=0, o_valid=0, o_data=0x00, o_frame_err=0, o_overrun=0.
REQ-029 Reset mid-byte SHALL abandon the partial byte and flush the FIFO, with no error pulses.

Structure
REQ-030 A shared package SHALL hold the receive state encoding and the CLKS_PER_BIT/HALF_BIT derivations, shared with the transmit side.
REQ-031 The FIFO SHALL be a separate sub-module, sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count); the receive FSM stays in uart_rx_buf.

Verification
REQ-032 Drive 0x55, then 0xA3, at 217 clk/bit with i_ready=1 -> o_data=0x55 then 0xA3, each shown with o_valid for one cycle; no flags.
REQ-033 Drive a 50-cycle low glitch on an idle line -> no push, o_count=0, no flags, state back in IDLE.
REQ-034 Drive 0x3C with stop bit 0, line held low for 1000 cycles, then 0x81 -> one o_frame_err pulse, 0x3C dropped, only 0x81 received.
REQ-035 Drive 9 bytes 0x01..0x09 with i_ready=0 -> o_count=8, one o_overrun pulse on byte 9; draining yields 0x01..0x08 in order.
REQ-036 With FIFO full, assert i_ready on the stop-sample cycle of a 10th byte -> byte accepted, o_count stays 8, no o_overrun.
REQ-037 Assert rst during DATA bit 4 with 3 bytes queued -> o_count=0, o_valid=0, and the next clean byte is received correctly.

Source files
------------

// File: rtl/uart_rx_buf_pkg.sv
// Shared UART definitions: receive state encoding and bit-timing derivations,
// common to the receive and transmit sides.
package uart_rx_buf_pkg;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t StIdle     = 3'd0;
  localparam rx_state_t StStart    = 3'd1;
  localparam rx_state_t StData     = 3'd2;
  localparam rx_state_t StStop     = 3'd3;
  localparam rx_state_t StWaitHigh = 3'd4;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic int unsigned half_bit(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clks_per_bit(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO. A push into a full FIFO is accepted
// only when a pop happens in the same cycle; head_o reads zero while empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PtrW   = $clog2(DEPTH),
  localparam int unsigned CountW = $clog2(DEPTH + 1)
) (
  input  logic              i_Clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [WIDTH-1:0]  push_data_i,
  input  logic              pop_i,
  output logic [WIDTH-1:0]  head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CountW-1:0] count_o
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == CountW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop_i && !empty_o;
    push_ok  = push_i && (!full_o || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap naturally since DEPTH is a power of two.
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CountW'(1);
      2'b01:   count_d = count_q - CountW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/uart_rx_buf.sv
// 8N1 UART receiver with a first-word-fall-through receive buffer, frame-error
// and overrun pulses.
module uart_rx_buf #(
  parameter int unsigned CLK_FREQ   = 25_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       i_Clk,
  input  logic       rst,
  input  logic       i_UART_RX,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic [4:0] o_count,
  output logic       o_frame_err,
  output logic       o_overrun
);
  import uart_rx_buf_pkg::*;

  localparam int unsigned ClksPerBit = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned HalfBit    = half_bit(CLK_FREQ, BAUD);
  localparam int unsigned CntW       = $clog2(ClksPerBit + 1);
  localparam int unsigned CountW     = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] BitEnd  = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] HalfEnd = CntW'(HalfBit - 1);

  logic            rx_meta_q, rx_meta_d;
  logic            rx_sync_q, rx_sync_d;
  rx_state_t       state_q, state_d;
  logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;

  logic              push, pop;
  logic              fifo_full, fifo_empty;
  logic [CountW-1:0] fifo_count;
  logic [7:0]        fifo_head;

  assign pop = !fifo_empty && i_ready;

  always_comb begin
    rx_meta_d   = i_UART_RX;
    rx_sync_d   = rx_meta_q;
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (!rx_sync_q) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (clk_cnt_q == HalfEnd) begin
          clk_cnt_d = '0;
          // A start bit that is gone by mid-bit was a glitch.
          state_d   = rx_sync_q ? StIdle : StData;
        end else begin
          clk_cnt_d = clk_cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (clk_cnt_q == BitEnd) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StStop;
        end else begin
          clk_cnt_d = clk_cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (clk_cnt_q == BitEnd) begin
          clk_cnt_d = '0;
          if (rx_sync_q) begin
            push    = 1'b1;
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitHigh;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CntW'(1);
        end
      end
      StWaitHigh: begin
        // Hold off until a break releases so it cannot look like a new start bit.
        if (rx_sync_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    overrun_d = push && fifo_full && !pop;
  end

  always_ff @(posedge i_Clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= StIdle;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clk       (i_Clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (shift_q),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign o_data      = fifo_head;
  assign o_valid     = !fifo_empty;
  assign o_count     = 5'(fifo_count);
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_buf.sv
// Directed bench for uart_rx_buf at default parameters (217 clocks per bit).
module tb_uart_rx_buf;
  import uart_rx_buf_pkg::*;

  localparam int unsigned Cpb = 217;
  // Posedge of the stop-bit sample, counted from the edge before the start bit is driven:
  // 2 sync + 1 detect + 108 half-bit + 8 data bits + 1 stop bit.
  localparam int unsigned StopSample = 3 + 108 + 9 * Cpb;

  logic       i_Clk = 1'b0;
  logic       rst;
  logic       i_UART_RX;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic [4:0] o_count;
  logic       o_frame_err;
  logic       o_overrun;

  int unsigned pass_cnt = 0;
  int unsigned fail_cnt = 0;
  int unsigned total_cnt = 0;

  logic [7:0]  popped[$];
  int unsigned valid_cycles = 0;
  int unsigned fe_cnt = 0;
  int unsigned ov_cnt = 0;

  always #5 i_Clk = ~i_Clk;

  uart_rx_buf dut (
    .i_Clk       (i_Clk),
    .rst         (rst),
    .i_UART_RX   (i_UART_RX),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_count     (o_count),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun)
  );

  // Observe outputs mid-cycle; a pop happens at the next posedge when valid and ready.
  always @(negedge i_Clk) begin
    if (o_valid) valid_cycles++;
    if (o_valid && i_ready) popped.push_back(o_data);
    if (o_frame_err) fe_cnt++;
    if (o_overrun) ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  // Called just after a posedge; leaves the line high just after the stop bit ends.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      i_UART_RX = bits[i];
      repeat (Cpb) @(posedge i_Clk);
      #1;
    end
    i_UART_RX = 1'b1;
  endtask

  task automatic clear_obs();
    popped.delete();
    valid_cycles = 0;
    fe_cnt = 0;
    ov_cnt = 0;
  endtask

  initial begin
    logic [7:0] exp_drain[9];
    rst = 1'b1;
    i_UART_RX = 1'b1;
    i_ready = 1'b0;
    idle(3);
    check("reset_count", o_count, 0);
    check("reset_valid", o_valid, 0);
    check("reset_data", o_data, 8'h00);
    check("reset_flags", {o_frame_err, o_overrun}, 2'b00);
    check("reset_state", dut.state_q, StIdle);
    rst = 1'b0;
    idle(5);

    // Two clean bytes, consumer always ready.
    clear_obs();
    i_ready = 1'b1;
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (StopSample - 1) @(posedge i_Clk);
        #1 check("lat_before_valid", o_valid, 0);
        @(posedge i_Clk);
        #1 check("lat_valid", o_valid, 1);
        check("lat_data", o_data, 8'h55);
      end
    join
    send_frame(8'hA3, 1'b1);
    idle(20);
    check("clean_npop", popped.size(), 2);
    check("clean_b0", popped[0], 8'h55);
    check("clean_b1", popped[1], 8'hA3);
    check("clean_valid_cycles", valid_cycles, 2);
    check("clean_flags", fe_cnt + ov_cnt, 0);

    // Short low glitch on an idle line.
    clear_obs();
    i_UART_RX = 1'b0;
    idle(50);
    i_UART_RX = 1'b1;
    idle(300);
    check("glitch_count", o_count, 0);
    check("glitch_npop", popped.size(), 0);
    check("glitch_flags", fe_cnt + ov_cnt, 0);
    check("glitch_state", dut.state_q, StIdle);

    // Bad stop bit followed by a long break, then a clean byte.
    clear_obs();
    send_frame(8'h3C, 1'b0);
    i_UART_RX = 1'b0;
    idle(1000);
    i_UART_RX = 1'b1;
    idle(20);
    check("ferr_pulses", fe_cnt, 1);
    check("ferr_npop", popped.size(), 0);
    check("ferr_count", o_count, 0);
    send_frame(8'h81, 1'b1);
    idle(20);
    check("ferr_after_npop", popped.size(), 1);
    check("ferr_after_byte", popped[0], 8'h81);
    check("ferr_after_pulses", fe_cnt, 1);

    // Nine bytes into a depth-8 FIFO with no consumer.
    clear_obs();
    i_ready = 1'b0;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
    idle(10);
    check("ovr_count", o_count, 8);
    check("ovr_pulses", ov_cnt, 1);
    check("ovr_head", o_data, 8'h01);
    check("ovr_valid", o_valid, 1);

    // Tenth byte while full, with a pop on the stop-sample cycle only.
    fork
      send_frame(8'h0A, 1'b1);
      begin
        repeat (StopSample - 1) @(posedge i_Clk);
        #1 i_ready = 1'b1;
        @(posedge i_Clk);
        #1 i_ready = 1'b0;
      end
    join
    idle(5);
    check("full_pp_count", o_count, 8);
    check("full_pp_pulses", ov_cnt, 1);
    check("full_pp_npop", popped.size(), 1);
    i_ready = 1'b1;
    idle(20);
    i_ready = 1'b0;
    exp_drain = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
    check("drain_npop", popped.size(), 9);
    for (int i = 0; i < 9; i++) check($sformatf("drain_b%0d", i), popped[i], exp_drain[i]);
    check("drain_count", o_count, 0);

    // Reset in the middle of a byte with three bytes queued.
    clear_obs();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    idle(5);
    check("rst_pre_count", o_count, 3);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        // Data bit 4 occupies clocks 1085..1302 of the frame.
        repeat (1150) @(posedge i_Clk);
        #1 rst = 1'b1;
        idle(4);
        check("rst_mid_count", o_count, 0);
        check("rst_mid_valid", o_valid, 0);
        check("rst_mid_data", o_data, 8'h00);
        rst = 1'b0;
      end
    join
    idle(20);
    check("rst_post_count", o_count, 0);
    check("rst_post_flags", fe_cnt + ov_cnt, 0);
    i_ready = 1'b1;
    send_frame(8'h5A, 1'b1);
    idle(20);
    check("rst_next_npop", popped.size(), 1);
    check("rst_next_byte", popped[0], 8'h5A);
    check("rst_next_flags", fe_cnt + ov_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
